seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scanner, successor to the fixed 4-digit scan block.
//  - Internal prescaler generates the scan tick.
//  - Tear-free frame-synchronous data update via load/pending.
//  - Per-digit decimal points, leading-zero suppression, 16-level PWM brightness.
//  - Sits between CPU debug/register-view logic and the board's common-anode digit/segment pins.

---
 rtl/seg7_scan_ctrl_if.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - frame-synchronous display data update bus
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  upd_pending;

  modport master (output load, output data_in, output dp_in, input upd_pending);
  modport slave  (input load, input data_in, input dp_in, output upd_pending);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed common-anode 7-segment scanner with tear-free update
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000,
  parameter int DIV_W  = 17
) (
  input  logic                CLK,
  input  logic                clr_n,
  seg7_scan_ctrl_if.slave     upd_bus,
  input  logic                lz_en,
  input  logic [3:0]          bright,
  input  logic                blank,
  output logic [DIGITS-1:0]   pos_ctrl,
  output logic [7:0]          num_ctrl
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int THR_W = DIV_W + 5;

  logic [DIV_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  boundary;
  logic [4*DIGITS-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic [4*DIGITS-1:0]   shown_data;
  logic [DIGITS-1:0]     shown_dp;
  logic [THR_W-1:0]      thr;
  logic [DIGITS-1:0]     supp;
  logic                  zero_run;
  logic [3:0]            nib;
  logic [7:0]            seg_val;
  logic                  dark;

  function automatic logic [7:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 8'hC0;
      4'h1: font = 8'hF9;
      4'h2: font = 8'hA4;
      4'h3: font = 8'hB0;
      4'h4: font = 8'h99;
      4'h5: font = 8'h92;
      4'h6: font = 8'h82;
      4'h7: font = 8'hF8;
      4'h8: font = 8'h80;
      4'h9: font = 8'h90;
      4'hA: font = 8'h88;
      4'hB: font = 8'h83;
      4'hC: font = 8'hC6;
      4'hD: font = 8'hA1;
      4'hE: font = 8'h86;
      default: font = 8'h8E;
    endcase
  endfunction

  assign tick     = (cnt == DIV_W'(DIV - 1));
  assign boundary = tick && (idx == '0);

  // On-time threshold inside a slot: floor((bright+1)*DIV/16); bright=15 covers the whole slot
  assign thr = ((THR_W'(bright) + THR_W'(1)) * THR_W'(DIV)) >> 4;

  // Prescaler and digit index; digits are scanned leftmost first, frame ends after digit 0
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
      idx <= IDX_W'(DIGITS - 1);
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == '0) ? IDX_W'(DIGITS - 1) : idx - IDX_W'(1);
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Pending/shown double buffer; a load in the boundary cycle wins over the commit-clear
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      pend_data           <= '0;
      pend_dp             <= '0;
      shown_data          <= '0;
      shown_dp            <= '0;
      upd_bus.upd_pending <= 1'b0;
    end else begin
      if (boundary && upd_bus.upd_pending) begin
        shown_data          <= pend_data;
        shown_dp            <= pend_dp;
        upd_bus.upd_pending <= 1'b0;
      end
      if (upd_bus.load) begin
        pend_data           <= upd_bus.data_in;
        pend_dp             <= upd_bus.dp_in;
        upd_bus.upd_pending <= 1'b1;
      end
    end
  end

  // Leading-zero map: a digit is suppressible when it and everything left of it is zero
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (shown_data[4*k +: 4] == 4'h0);
      if (k != 0) supp[k] = zero_run;
    end
  end

  // Segment pattern and darkness decision for the active digit
  always_comb begin
    nib     = shown_data[4*idx +: 4];
    seg_val = font(nib);
    if (shown_dp[idx]) seg_val[7] = 1'b0;
    dark    = blank || (lz_en && supp[idx]) || (THR_W'(cnt) >= thr);
  end

  // Registered pin drive; at most one digit enable is ever low
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      pos_ctrl <= '1;
      num_ctrl <= 8'hFF;
    end else if (dark) begin
      pos_ctrl <= '1;
      num_ctrl <= 8'hFF;
    end else begin
      pos_ctrl <= ~(DIGITS'(1) << idx);
      num_ctrl <= seg_val;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed vector bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
  logic       CLK;
  logic       clr_n;
  logic       lz_en;
  logic [3:0] bright;
  logic       blank;
  logic [3:0] pos_ctrl;
  logic [7:0] num_ctrl;

  int passed;
  int total;
  int cyc;

  seg7_scan_ctrl_if #(.DIGITS(4)) bus ();

  seg7_scan_ctrl #(.DIGITS(4), .DIV(8), .DIV_W(4)) dut (
    .CLK      (CLK),
    .clr_n    (clr_n),
    .upd_bus  (bus),
    .lz_en    (lz_en),
    .bright   (bright),
    .blank    (blank),
    .pos_ctrl (pos_ctrl),
    .num_ctrl (num_ctrl)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0]      bright;
    logic            blank;
    logic [3:0][7:0] exp;
    int              thr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_state(input int t);
    for (int i = 0; i < 64 && (cyc % 32) != t; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    bus.data_in = d;
    bus.dp_in   = dp;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
  endtask

  // Checks one full frame starting at state 0; exp[k]==FF means digit k dark
  task automatic check_frame(input logic [3:0][7:0] exp, input int thr, input string tag);
    int         di;
    int         ci;
    logic       dk;
    logic [3:0] ep;
    logic [7:0] en;
    for (int s = 0; s < 32; s++) begin
      step();
      di = 3 - s / 8;
      ci = s % 8;
      dk = (exp[di] == 8'hFF) || (ci >= thr);
      ep = 4'b0001 << di;
      ep = dk ? 4'hF : ~ep;
      en = dk ? 8'hFF : exp[di];
      chk($sformatf("%s pos s%0d", tag, s), {28'd0, pos_ctrl}, {28'd0, ep});
      chk($sformatf("%s num s%0d", tag, s), {24'd0, num_ctrl}, {24'd0, en});
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    vecs[0]  = '{16'h12AF, 4'h0, 1'b0, 4'd15, 1'b0, 32'hF9A4888E, 8};
    vecs[1]  = '{16'h0040, 4'h0, 1'b1, 4'd15, 1'b0, 32'hFFFF99C0, 8};
    vecs[2]  = '{16'h0000, 4'h0, 1'b1, 4'd15, 1'b0, 32'hFFFFFFC0, 8};
    vecs[3]  = '{16'h12AF, 4'h0, 1'b0, 4'd3,  1'b0, 32'hF9A4888E, 2};
    vecs[4]  = '{16'h12AF, 4'h0, 1'b0, 4'd0,  1'b0, 32'hF9A4888E, 0};
    vecs[5]  = '{16'h0050, 4'h2, 1'b1, 4'd15, 1'b0, 32'hFFFF12C0, 8};
    vecs[6]  = '{16'h0005, 4'h8, 1'b1, 4'd15, 1'b0, 32'hFFFFFF92, 8};
    vecs[7]  = '{16'h12AF, 4'h0, 1'b0, 4'd15, 1'b1, 32'hFFFFFFFF, 8};
    vecs[8]  = '{16'h3456, 4'hF, 1'b1, 4'd15, 1'b0, 32'h30191202, 8};
    vecs[9]  = '{16'h12AF, 4'h0, 1'b0, 4'd7,  1'b0, 32'hF9A4888E, 4};
    vecs[10] = '{16'h0C0D, 4'h0, 1'b1, 4'd15, 1'b0, 32'hFFC6C0A1, 8};

    clr_n       = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.dp_in   = '0;
    lz_en       = 1'b0;
    bright      = 4'd15;
    blank       = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset pos", {28'd0, pos_ctrl}, 32'hF);
    chk("reset num", {24'd0, num_ctrl}, 32'hFF);
    chk("reset upd", {31'd0, bus.upd_pending}, 32'd0);
    clr_n = 1'b1;
    cyc   = 0;
    step();
    chk("first slot pos", {28'd0, pos_ctrl}, 32'h7);
    chk("first slot num", {24'd0, num_ctrl}, 32'hC0);

    for (int v = 0; v < 11; v++) begin
      wait_state(5);
      lz_en  = vecs[v].lz;
      bright = vecs[v].bright;
      blank  = vecs[v].blank;
      do_load(vecs[v].data, vecs[v].dp);
      chk($sformatf("v%0d upd set", v), {31'd0, bus.upd_pending}, 32'd1);
      wait_state(0);
      chk($sformatf("v%0d upd clr", v), {31'd0, bus.upd_pending}, 32'd0);
      check_frame(vecs[v].exp, vecs[v].thr, $sformatf("v%0d", v));
    end

    // back-to-back loads mid-frame: last wins, shown untouched until boundary
    wait_state(10);
    bus.data_in = 16'h1111;
    bus.load    = 1'b1;
    step();
    bus.data_in = 16'h2222;
    step();
    bus.load    = 1'b0;
    chk("b2b upd", {31'd0, bus.upd_pending}, 32'd1);
    wait_state(17);
    step();
    chk("b2b old pos", {28'd0, pos_ctrl}, 32'hD);
    chk("b2b old num", {24'd0, num_ctrl}, 32'hC0);
    wait_state(0);
    chk("b2b upd clr", {31'd0, bus.upd_pending}, 32'd0);
    check_frame(32'hA4A4A4A4, 8, "b2b");

    // load on boundary while pending: old pending shown, new one a frame later
    wait_state(20);
    do_load(16'h3333, 4'h0);
    wait_state(31);
    do_load(16'h4444, 4'h0);
    chk("bnd pend upd", {31'd0, bus.upd_pending}, 32'd1);
    check_frame(32'hB0B0B0B0, 8, "bnd1");
    chk("bnd pend upd2", {31'd0, bus.upd_pending}, 32'd0);
    check_frame(32'h99999999, 8, "bnd2");

    // load on boundary with nothing pending: waits a whole frame
    wait_state(31);
    do_load(16'h5555, 4'h0);
    chk("bnd idle upd", {31'd0, bus.upd_pending}, 32'd1);
    check_frame(32'h99999999, 8, "idle1");
    chk("bnd idle upd2", {31'd0, bus.upd_pending}, 32'd0);
    check_frame(32'h92929292, 8, "idle2");

    // asynchronous reset mid-slot clears outputs and buffers immediately
    wait_state(1);
    do_load(16'h6666, 4'h0);
    chk("pre-rst upd", {31'd0, bus.upd_pending}, 32'd1);
    wait_state(3);
    clr_n = 1'b0;
    #1;
    chk("async rst pos", {28'd0, pos_ctrl}, 32'hF);
    chk("async rst num", {24'd0, num_ctrl}, 32'hFF);
    chk("async rst upd", {31'd0, bus.upd_pending}, 32'd0);
    lz_en = 1'b0;
    #1;
    clr_n = 1'b1;
    cyc   = 0;
    step();
    chk("post-rst pos", {28'd0, pos_ctrl}, 32'h7);
    chk("post-rst num", {24'd0, num_ctrl}, 32'hC0);
    wait_state(0);
    chk("post-rst upd", {31'd0, bus.upd_pending}, 32'd0);
    check_frame(32'hC0C0C0C0, 8, "postrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
